// File: rtl/md_sequencer.sv
// Iterative multiply/divide unit with HI/LO register file for the MIPS core.
// A 32-step shift-add multiply or restoring divide runs on latched magnitudes; signs are fixed in FIX.
module md_sequencer #(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mdstart,
  input  logic [1:0]       mdop,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hiloread,
  input  logic             hilosel,
  input  logic [1:0]       hilowrite,
  input  logic [WIDTH-1:0] hilowd,
  output logic [WIDTH-1:0] hilo_out,
  output logic             busy,
  output logic             stall,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = $clog2(ITERS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               mul_q, mul_d;
  logic               neg_q, neg_d;
  logic               dneg_q, dneg_d;
  logic               div0_q, div0_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_rs;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // Magnitudes are taken as unsigned, so 0x80000000 maps to 2^31 without overflow.
  assign a_mag = (mdop[1] && srca[WIDTH-1]) ? -srca : srca;
  assign b_mag = (mdop[1] && srcb[WIDTH-1]) ? -srcb : srcb;

  // p_q holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  assign mul_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : '0);
  assign div_rs   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign div_diff = {1'b0, div_rs} - {2'b00, b_q};

  assign prod_fix = neg_q ? -p_q : p_q;
  assign quot_fix = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
  assign rem_fix  = dneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    p_d     = p_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mul_d   = mul_q;
    neg_d   = neg_q;
    dneg_d  = dneg_q;
    div0_d  = div0_q;
    case (state_q)
      S_IDLE: begin
        if (hilowrite[1]) hi_d = hilowd;
        if (hilowrite[0]) lo_d = hilowd;
        if (mdstart) begin
          mul_d   = mdop[0];
          neg_d   = mdop[1] & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
          dneg_d  = mdop[1] & srca[WIDTH-1];
          div0_d  = (srcb == '0);
          b_d     = b_mag;
          p_d     = {{WIDTH{1'b0}}, a_mag};
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (mul_q) begin
          p_d = {mul_sum, p_q[WIDTH-1:1]};
        end else if (div_diff[WIDTH+1]) begin
          p_d = {div_rs[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
        end else begin
          p_d = {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITERS - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (mul_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else begin
          hi_d = rem_fix;
          lo_d = div0_q ? '1 : quot_fix;
        end
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      b_q     <= '0;
      p_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mul_q   <= 1'b0;
      neg_q   <= 1'b0;
      dneg_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      p_q     <= p_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mul_q   <= mul_d;
      neg_q   <= neg_d;
      dneg_q  <= dneg_d;
      div0_q  <= div0_d;
    end
  end

  // Handshake: while busy, mdstart/hilowrite are dropped and stall tells the pipeline to hold and reissue.
  assign busy        = (state_q != S_IDLE);
  assign stall       = busy & (hiloread | mdstart | (|hilowrite));
  assign hilo_out    = hilosel ? hi_q : lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: directed cases plus randomized ops against a
// behavioural arithmetic model of MULT/MULTU/DIV/DIVU and the HI/LO register file.
module tb_md_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         mdstart;
  logic [1:0]   mdop;
  logic [W-1:0] srca, srcb;
  logic         hiloread, hilosel;
  logic [1:0]   hilowrite;
  logic [W-1:0] hilowd;
  logic [W-1:0] hilo_out;
  logic         busy, stall;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_hi, m_lo;

  md_sequencer #(.WIDTH(W), .ITERS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .mdstart    (mdstart),
    .mdop       (mdop),
    .srca       (srca),
    .srcb       (srcb),
    .hiloread   (hiloread),
    .hilosel    (hilosel),
    .hilowrite  (hilowrite),
    .hilowd     (hilowd),
    .hilo_out   (hilo_out),
    .busy       (busy),
    .stall      (stall),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic with the architectural corner cases.
  function automatic void ref_md(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] hi, output logic [W-1:0] lo);
    logic [63:0] p;
    int sa, sb;
    if (op[0]) begin
      if (op[1]) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      else       p = {32'd0, a} * {32'd0, b};
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
    end else if (op[1]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        hi = 32'd0;
        lo = 32'h8000_0000;
      end else begin
        sa = $signed(a);
        sb = $signed(b);
        lo = sa / sb;
        hi = sa % sb;
      end
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction

  task automatic check_regs(input string tag);
    hilosel = 1'b1;
    #1 check({tag, ".hi"}, hilo_out, m_hi);
    hilosel = 1'b0;
    #1 check({tag, ".lo"}, hilo_out, m_lo);
  endtask

  task automatic idle_inputs();
    mdstart   = 1'b0;
    hiloread  = 1'b0;
    hilowrite = 2'b00;
  endtask

  // mode 0: quiet; 1: random interference while busy; 2: hold MFLO from cycle 5 plus a blocked MULT/MTHI.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int mode, input bit with_wr);
    logic [W-1:0] h, l, wd;
    int n;
    ref_md(op, a, b, h, l);
    exp_q.push_back(h);
    exp_q.push_back(l);
    wd = $urandom;
    @(negedge clk);
    mdstart = 1'b1; mdop = op; srca = a; srcb = b;
    if (with_wr) begin
      hilowrite = 2'b11;
      hilowd    = wd;
    end
    @(negedge clk);
    idle_inputs();
    srca = $urandom;
    srcb = $urandom;
    if (with_wr) begin
      m_hi = wd;
      m_lo = wd;
      check_regs("start_wr");
    end
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (mode == 1) begin
        mdstart   = ($urandom_range(0, 3) == 0);
        hiloread  = ($urandom_range(0, 2) == 0);
        hilowrite = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        hilowd    = $urandom;
        mdop      = 2'($urandom_range(0, 3));
        hilosel   = 1'($urandom_range(0, 1));
      end else if (mode == 2) begin
        hiloread  = (n >= 5);
        hilosel   = 1'b0;
        mdstart   = (n >= 8 && n < 12);
        hilowrite = (n >= 10 && n < 14) ? 2'b10 : 2'b00;
        hilowd    = 32'hDEAD_BEEF;
      end
      #1 check("stall_busy", stall, hiloread | mdstart | (|hilowrite));
      @(negedge clk);
    end
    idle_inputs();
    check("busy_cycles", n, 33);
    m_hi = exp_q.pop_front();
    m_lo = exp_q.pop_front();
    check_regs("op_result");
    hiloread = 1'b1;
    #1 check("stall_idle", stall, 1'b0);
    hiloread = 1'b0;
  endtask

  task automatic mt(input logic [1:0] wr, input logic [W-1:0] d);
    @(negedge clk);
    hilowrite = wr;
    hilowd    = d;
    hiloread  = 1'b1;
    hilosel   = 1'b1;
    #1 check("mt_no_fwd_hi", hilo_out, m_hi);
    check("mt_stall", stall, 1'b0);
    hilosel = 1'b0;
    #1 check("mt_no_fwd_lo", hilo_out, m_lo);
    @(negedge clk);
    idle_inputs();
    if (wr[1]) m_hi = d;
    if (wr[0]) m_lo = d;
    check_regs("mt");
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    mdop = 2'b00; srca = '0; srcb = '0; hilosel = 1'b0; hilowd = '0;
    idle_inputs();
    m_hi = '0;
    m_lo = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    hiloread = 1'b1;
    #1 check("rst_busy", busy, 1'b0);
    check("rst_stall", stall, 1'b0);
    hiloread = 1'b0;
    check_regs("rst");

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    check("multu_hi_const", m_hi, 32'hFFFF_FFFE);
    run_op(2'b11, 32'hFFFF_FFFE, 32'd7, 0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_op(2'b00, 32'd100, 32'd0, 0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 0, 1'b0);
    run_op(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 2, 1'b0);
    run_op(2'b01, 32'd6, 32'd9, 0, 1'b1);

    mt(2'b11, 32'h0000_ABCD);
    mt(2'b01, 32'h0000_5678);
    mt(2'b10, 32'h0000_1234);

    // Reset ten cycles into a divide abandons it and clears HI/LO.
    @(negedge clk);
    mdstart = 1'b1; mdop = 2'b10; srca = 32'd1000; srcb = 32'd7;
    @(negedge clk);
    idle_inputs();
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    #1 check("abort_busy", busy, 1'b0);
    check_regs("abort");
    run_op(2'b01, 32'd3, 32'd5, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(), int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
